// File: rtl/stride_chk_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : stride_chk_pkg
// Description : Shared types and default constants for the stride-sequence
//               checker: the two-state lock FSM encoding and the default
//               width / step / lock / unlock thresholds.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
package stride_chk_pkg;

    // Lock state of the checker; explicit 1-bit encoding.
    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int c_width_default         = 8;
    localparam int c_step_default          = 2;
    localparam int c_lock_thresh_default   = 4;
    localparam int c_unlock_thresh_default = 2;

endpackage : stride_chk_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : Up-counter that increments on inc_i and holds at all-ones.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous active-high reset, clears the count
//               inc_i    - increment request for this cycle
//               count_o  - current registered count
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc_i && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/stride_seq_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : stride_seq_checker
// Description : Locks onto an arithmetic progression (step STEP, modulo
//               2^WIDTH) carried on a valid-qualified stream, then flags and
//               counts every sample that breaks it. Lock is dropped after
//               UNLOCK_THRESH consecutive misses.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous active-high reset
//               valid_i    - data_i carries a sample this cycle
//               data_i     - sample value
//               locked_o   - checker is locked to the progression
//               err_o      - one-cycle pulse per mismatching sample when locked
//               err_cnt_o  - saturating count of err_o pulses
//               exp_o      - value expected for the next valid sample
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module stride_seq_checker
    import stride_chk_pkg::*;
#(
    parameter int WIDTH         = c_width_default,
    parameter int STEP          = c_step_default,
    parameter int LOCK_THRESH   = c_lock_thresh_default,
    parameter int UNLOCK_THRESH = c_unlock_thresh_default,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [WIDTH-1:0]     exp_o
);

    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int MISS_W = $clog2(UNLOCK_THRESH + 1);

    localparam logic [WIDTH-1:0]  c_step          = WIDTH'(STEP);
    localparam logic [RUN_W-1:0]  c_lock_thresh   = RUN_W'(LOCK_THRESH);
    localparam logic [MISS_W-1:0] c_unlock_thresh = MISS_W'(UNLOCK_THRESH);

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_exp, w_exp_nxt;
    logic [RUN_W-1:0]    r_run, w_run_nxt;
    logic [MISS_W-1:0]   r_miss, w_miss_nxt;
    logic                r_seeded, w_seeded_nxt;
    logic                r_err, w_err_nxt;

    logic                w_match;
    logic [WIDTH-1:0]    w_exp_step;
    logic [WIDTH-1:0]    w_data_step;
    logic [RUN_W-1:0]    w_run_inc;
    logic [MISS_W-1:0]   w_miss_inc;

    // Sums truncate to WIDTH bits, which gives the modulo-2^WIDTH wrap.
    assign w_match     = (data_i == r_exp);
    assign w_exp_step  = r_exp + c_step;
    assign w_data_step = data_i + c_step;
    assign w_run_inc   = r_run + 1'b1;
    assign w_miss_inc  = r_miss + 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; err_o is registered so it lines up with the
    // state and counter updates for the same sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp    <= '0;
            r_run    <= '0;
            r_miss   <= '0;
            r_seeded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_exp    <= w_exp_nxt;
            r_run    <= w_run_nxt;
            r_miss   <= w_miss_nxt;
            r_seeded <= w_seeded_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state / datapath logic
    always_comb begin
        w_state_nxt  = r_state;
        w_exp_nxt    = r_exp;
        w_run_nxt    = r_run;
        w_miss_nxt   = r_miss;
        w_seeded_nxt = r_seeded;
        w_err_nxt    = 1'b0;

        if (valid_i) begin
            case (r_state)
                ST_HUNT: begin
                    if (!r_seeded || !w_match) begin
                        // Restart the progression from this sample.
                        w_exp_nxt    = w_data_step;
                        w_run_nxt    = '0;
                        w_seeded_nxt = 1'b1;
                    end else begin
                        w_exp_nxt = w_exp_step;
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == c_lock_thresh) begin
                            w_state_nxt = ST_LOCKED;
                            w_miss_nxt  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_match) begin
                        w_exp_nxt  = w_exp_step;
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == c_unlock_thresh) begin
                            w_state_nxt = ST_HUNT;
                            w_exp_nxt   = w_data_step;
                            w_run_nxt   = '0;
                            w_miss_nxt  = '0;
                        end else begin
                            // Keep alignment: a lone corrupt sample must not
                            // shift the expected sequence.
                            w_exp_nxt = w_exp_step;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    // Counter advances on the same edge that raises err_o.
    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_err_nxt),
        .count_o (err_cnt_o)
    );

    assign locked_o = (r_state == ST_LOCKED);
    assign err_o    = r_err;
    assign exp_o    = r_exp;

endmodule : stride_seq_checker
`default_nettype wire

// File: tb/tb_stride_seq_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_stride_seq_checker
// Description : Directed self-checking bench. Instance A uses default
//               parameters; instance B has a 2-bit error counter to reach
//               saturation quickly.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stride_seq_checker;

    logic        clk;
    logic        rst_a, rst_b;
    logic        valid_a, valid_b;
    logic [7:0]  data_a, data_b;
    logic        locked_a, locked_b;
    logic        err_a, err_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [7:0]  exp_a, exp_b;

    int checks = 0;
    int errors = 0;

    stride_seq_checker #(
        .WIDTH(8), .STEP(2), .LOCK_THRESH(4), .UNLOCK_THRESH(2), .ERR_CNT_W(16)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .valid_i(valid_a), .data_i(data_a),
        .locked_o(locked_a), .err_o(err_a), .err_cnt_o(cnt_a), .exp_o(exp_a)
    );

    stride_seq_checker #(
        .WIDTH(8), .STEP(2), .LOCK_THRESH(4), .UNLOCK_THRESH(2), .ERR_CNT_W(2)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .valid_i(valid_b), .data_i(data_b),
        .locked_o(locked_b), .err_o(err_b), .err_cnt_o(cnt_b), .exp_o(exp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed number of cycles, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Drive one valid sample at the negedge; result observed #1 after posedge.
    task automatic send_a(input logic [7:0] d);
        @(negedge clk);
        valid_a = 1'b1;
        data_a  = d;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = d;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_a = 1'b0;
            data_a  = 8'hEE;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1;
        #1;
        checks++;
        if (locked_a !== 1'b0 || err_a !== 1'b0 || cnt_a !== 16'd0 || exp_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: locked=%b err=%b cnt=%0d exp=%h, expected 0 0 0 00",
                     locked_a, err_a, cnt_a, exp_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    task automatic test_lock;
        logic [7:0] seq [5];
        logic [7:0] exp_v [5];
        seq   = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09};
        exp_v = '{8'h03, 8'h05, 8'h07, 8'h09, 8'h0B};
        for (int i = 0; i < 5; i++) begin
            send_a(seq[i]);
            checks++;
            if (locked_a !== (i == 4) || err_a !== 1'b0 || exp_a !== exp_v[i]) begin
                errors++;
                $display("FAIL lock_seq[%0d]: locked=%b err=%b exp=%h, expected %b 0 %h",
                         i, locked_a, err_a, exp_a, (i == 4), exp_v[i]);
            end
        end
    endtask

    task automatic test_single_glitch;
        send_a(8'h20);
        checks++;
        if (err_a !== 1'b1 || cnt_a !== 16'd1 || locked_a !== 1'b1 || exp_a !== 8'h0D) begin
            errors++;
            $display("FAIL glitch_hit: err=%b cnt=%0d locked=%b exp=%h, expected 1 1 1 0d",
                     err_a, cnt_a, locked_a, exp_a);
        end
        send_a(8'h0D);
        checks++;
        if (err_a !== 1'b0 || cnt_a !== 16'd1 || locked_a !== 1'b1 || exp_a !== 8'h0F) begin
            errors++;
            $display("FAIL glitch_recover: err=%b cnt=%0d locked=%b exp=%h, expected 0 1 1 0f",
                     err_a, cnt_a, locked_a, exp_a);
        end
    endtask

    task automatic test_loss_of_lock;
        send_a(8'h40);
        checks++;
        if (err_a !== 1'b1 || cnt_a !== 16'd2 || locked_a !== 1'b1 || exp_a !== 8'h11) begin
            errors++;
            $display("FAIL miss1: err=%b cnt=%0d locked=%b exp=%h, expected 1 2 1 11",
                     err_a, cnt_a, locked_a, exp_a);
        end
        idle_a(3);
        checks++;
        if (err_a !== 1'b0 || cnt_a !== 16'd2 || locked_a !== 1'b1 || exp_a !== 8'h11) begin
            errors++;
            $display("FAIL idle_hold: err=%b cnt=%0d locked=%b exp=%h, expected 0 2 1 11",
                     err_a, cnt_a, locked_a, exp_a);
        end
        send_a(8'h50);
        checks++;
        if (err_a !== 1'b1 || cnt_a !== 16'd3 || locked_a !== 1'b0 || exp_a !== 8'h52) begin
            errors++;
            $display("FAIL unlock: err=%b cnt=%0d locked=%b exp=%h, expected 1 3 0 52",
                     err_a, cnt_a, locked_a, exp_a);
        end
        idle_a(2);
        // In HUNT a mismatch reseeds silently.
        send_a(8'h77);
        checks++;
        if (err_a !== 1'b0 || cnt_a !== 16'd3 || locked_a !== 1'b0 || exp_a !== 8'h79) begin
            errors++;
            $display("FAIL hunt_reseed: err=%b cnt=%0d locked=%b exp=%h, expected 0 3 0 79",
                     err_a, cnt_a, locked_a, exp_a);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] seq [6];
        logic [7:0] exp_v [6];
        seq   = '{8'hF9, 8'hFB, 8'hFD, 8'hFF, 8'h01, 8'h03};
        exp_v = '{8'hFB, 8'hFD, 8'hFF, 8'h01, 8'h03, 8'h05};
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_a(seq[i]);
            checks++;
            if (locked_a !== (i >= 4) || err_a !== 1'b0 || exp_a !== exp_v[i]) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: locked=%b err=%b exp=%h, expected %b 0 %h",
                         i, locked_a, err_a, exp_a, (i >= 4), exp_v[i]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_cnt;
        logic [7:0] e;
        for (int i = 0; i < 5; i++) send_b(8'h01 + 8'(2 * i));
        checks++;
        if (locked_b !== 1'b1 || exp_b !== 8'h0B) begin
            errors++;
            $display("FAIL sat_lock: locked=%b exp=%h, expected 1 0b", locked_b, exp_b);
        end
        e = 8'h0B;
        exp_cnt = 2'd0;
        for (int g = 0; g < 5; g++) begin
            send_b(8'hAA);
            e = e + 8'd2;
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            checks++;
            if (err_b !== 1'b1 || cnt_b !== exp_cnt || locked_b !== 1'b1) begin
                errors++;
                $display("FAIL sat_glitch[%0d]: err=%b cnt=%0d locked=%b, expected 1 %0d 1",
                         g, err_b, cnt_b, locked_b, exp_cnt);
            end
            send_b(e);
            e = e + 8'd2;
        end
        checks++;
        if (cnt_b !== 2'd3 || locked_b !== 1'b1 || exp_b !== e) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d locked=%b exp=%h, expected 3 1 %h",
                     cnt_b, locked_b, exp_b, e);
        end
        // Asynchronous reset mid-stream, away from any clock edge.
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = e;
        #2;
        rst_b = 1'b1;
        #1;
        checks++;
        if (locked_b !== 1'b0 || cnt_b !== 2'd0 || exp_b !== 8'h00 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: locked=%b cnt=%0d exp=%h err=%b, expected 0 0 00 0",
                     locked_b, cnt_b, exp_b, err_b);
        end
        valid_b = 1'b0;
    endtask

    // Sample presented while reset is released is the seed on the first edge.
    task automatic test_seed_after_release;
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = 8'h10;
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        checks++;
        if (exp_b !== 8'h12 || locked_b !== 1'b0 || cnt_b !== 2'd0) begin
            errors++;
            $display("FAIL seed_after_reset: exp=%h locked=%b cnt=%0d, expected 12 0 0",
                     exp_b, locked_b, cnt_b);
        end
        for (int i = 1; i < 5; i++) send_b(8'h10 + 8'(2 * i));
        checks++;
        if (locked_b !== 1'b1 || exp_b !== 8'h1A) begin
            errors++;
            $display("FAIL relock: locked=%b exp=%h, expected 1 1a", locked_b, exp_b);
        end
    endtask

    initial begin
        valid_a = 1'b0; data_a = 8'h00;
        valid_b = 1'b0; data_b = 8'h00;
        rst_a = 1'b1; rst_b = 1'b1;
        test_reset;
        test_lock;
        test_single_glitch;
        test_loss_of_lock;
        test_wrap;
        test_saturation;
        test_seed_after_release;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stride_seq_checker
`default_nettype wire

// File: doc/stride_seq_checker.md
# stride_seq_checker

Receive-side monitor for the stride-counter streams our counter blocks generate (e.g. the odd-number sequence 1, 3, 5, … with step 2). It samples a valid-qualified WIDTH-bit value stream and locks onto the arithmetic progression. Once locked, it flags and counts every sample that breaks the progression, and drops lock after a run of consecutive misses. It sits at the far end of a count bus as a link/integrity checker, with status exposed for debug and self-test.

## Interface
- WIDTH, 8: data width; all sequence arithmetic is modulo 2^WIDTH.
- STEP, 2: expected increment between consecutive valid samples.
- LOCK_THRESH, 4: consecutive matching samples, after the seed sample, required to lock (≥1).
- UNLOCK_THRESH, 2: consecutive mismatches in LOCKED that force loss of lock (≥1).
- ERR_CNT_W, 16: width of the error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  data_i holds a sample this cycle.
- data_i  input  WIDTH  sample value.
- locked_o  output  1  checker is in LOCKED.
- err_o  output  1  one-cycle pulse per mismatching sample while LOCKED.
- err_cnt_o  output  ERR_CNT_W  saturating count of err_o pulses.
- exp_o  output  WIDTH  value expected for the next valid sample (debug).

## Operation
- States: HUNT (reset state) and LOCKED.
- The state enum is 1 bit wide. Internal registers:
  - run: match counter, clog2(LOCK_THRESH+1) bits.
  - miss: miss counter, clog2(UNLOCK_THRESH+1) bits.
  - seeded: flag.
- Cycles with valid_i=0: no state change, no pulse, exp_o held. Gaps between samples are legal.
- HUNT behaviour on each valid sample:
  - If not seeded, or data_i ≠ exp: set exp = data_i+STEP, run=0, seeded=1.
  - If data_i == exp: set exp += STEP, run++. When run reaches LOCK_THRESH, go to LOCKED with miss=0.
  - err_o is never asserted in HUNT.
- LOCKED behaviour on each valid sample:
  - Match: exp += STEP, miss=0.
  - Mismatch: err_o=1 for one cycle and err_cnt increments, saturating at all-ones. miss++.
    - If miss reaches UNLOCK_THRESH: go to HUNT, reseed with exp = data_i+STEP, run=0.
    - Otherwise stay LOCKED. exp still advances by STEP, so an isolated corrupt sample does not shift alignment.
- Wrap-around: exp is computed modulo 2^WIDTH. For WIDTH=8, STEP=2: 0xFF → 0x01 is a match.
- err_cnt_o is cleared only by reset. It is not cleared by loss of lock.

## Timing
- All outputs are registered. The response to a sample taken at edge N is visible after edge N, one-cycle latency.
- The lock transition and the err_o pulse appear in the same cycle as the other register updates for that sample.
- locked_o rises after the sample that completes LOCK_THRESH matches. With defaults, that is the 5th valid sample.
- locked_o falls after the sample that completes UNLOCK_THRESH misses. err_o is also high for that sample.
- Reset (asynchronous, any time, including mid-lock):
  - Outputs: locked_o=0, err_o=0, err_cnt_o=0, exp_o=0.
  - Internal: seeded=0, run=0, miss=0.
  - A valid sample on the first edge after reset release is treated as the seed.

## Structure
- Package stride_chk_pkg holds:
  - the state enum (ST_HUNT, ST_LOCKED);
  - default constants for WIDTH, STEP, LOCK_THRESH and UNLOCK_THRESH.
- One natural sub-module: sat_counter (parameterised width, increment enable, saturates at all-ones). It is instantiated for err_cnt.
- All other logic is one FSM plus datapath in the top module.

## Test plan
- Lock:
  - Stimulus: reset, then valid samples 1, 3, 5, 7, 9.
  - Response: locked_o=1 after the 5th sample; err_o never asserted; exp_o=0x0B.
- Wrap:
  - Stimulus: samples 0xF9, 0xFB, 0xFD, 0xFF, 0x01, 0x03.
  - Response: locked after 0x01; no err_o at the 0xFF → 0x01 boundary; exp_o=0x05.
- Single glitch:
  - Stimulus: locked at 9, then samples 0x20, 13.
  - Response: one err_o pulse; err_cnt_o=1; locked_o stays 1; 13 matches.
- Loss of lock and gaps:
  - Stimulus: locked, then samples 0x40, 0x50, with idle cycles between valids.
  - Response: two err_o pulses; locked_o=0 after 0x50; exp_o=0x52; idle cycles change nothing.
- Saturation and reset:
  - Stimulus: ERR_CNT_W=2, five isolated glitches while locked, then reset asserted mid-stream.
  - Response: err_cnt_o stops at 3. Reset immediately gives locked_o=0, err_cnt_o=0, exp_o=0.
